i2c_nco_top: RTL and testbench

I2C-programmable numerically controlled oscillator (NCO). A 7-bit-address I2C write-only slave receives a control byte, plus an optional 64-bit frequency word and an optional 16-bit duty-cycle word. On STOP it commits them to a phase-accumulator NCO. The NCO emits an unsigned RESOLUTION-bit waveform sample stream; the block is the top level between the external I2C bus and the DAC path.

---
 rtl/i2c_nco_top_pkg.sv | 53 +++++
 rtl/i2c_nco_top_i2c_slave.sv | 180 ++++++++++++++++++
 rtl/i2c_nco_top.sv | 129 ++++++++++++
 tb/tb_i2c_nco_top.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_nco_top_pkg.sv
// Shared types and constants for the I2C-programmable NCO.
// Sine ROM helper is only referenced when SINE_LUT_EN is defined.
package i2c_nco_top_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    DATA     = 3'd3,
    DATA_ACK = 3'd4
  } i2c_state_e;

  localparam logic [6:0] SLAVE_ADDR = 7'b1110101;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_WAVE = 1;
  localparam int CTRL_FREQ = 4;
  localparam int CTRL_DUTY = 5;

  localparam int FREQ_W = 64;
  localparam int DUTY_W = 16;
  localparam int CTRL_W = 8;

  localparam logic [DUTY_W-1:0] DUTY_RST = 16'h8000;

  typedef struct packed {
    logic              en;
    logic [1:0]        wave;
    logic [31:0]       freq;
    logic [DUTY_W-1:0] duty;
  } nco_cfg_t;

  // Quarter-wave sample i of 64, centred in its slot, scaled to
  // 2^(res-1)-1. Fixed-point Taylor series so it folds to a constant.
  function automatic int sine_amp(input int idx, input int res);
    longint pi_q30;
    longint x;
    longint t;
    longint s;
    longint a;
    pi_q30 = 64'sd3373259426;
    x = ((2 * longint'(idx) + 1) * pi_q30) / 256;
    t = x;
    s = x;
    for (int k = 1; k <= 5; k++) begin
      t = -((((t * x) >>> 30) * x) >>> 30) / longint'((2 * k) * (2 * k + 1));
      s = s + t;
    end
    a = (longint'(1) << (res - 1)) - 1;
    return int'((s * a + (longint'(1) << 29)) >>> 30);
  endfunction

endpackage

// File: rtl/i2c_nco_top_i2c_slave.sv
// Write-only I2C slave: synchronizers, START/STOP detect, byte FSM,
// payload shifters and shadow config committed on STOP.
module i2c_slave
  import i2c_nco_top_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     scl_i,
  inout  wire      sda_io,
  output logic     start_o,
  output logic     ack_error_o,
  output nco_cfg_t cfg_o,
  output logic     cfg_vld_o
);

  logic [1:0] scl_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  i2c_state_e state, state_d;
  logic [6:0]        cnt_q, cnt_d;
  logic [7:0]        addr_q, addr_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              pend_q, pend_d;
  logic              sda_low_q, sda_low_d;
  logic              start_q, start_d;
  logic              ack_err_q, ack_err_d;
  logic              vld_q, vld_d;
  nco_cfg_t          cfg_q, cfg_d;
  logic [6:0]        plen;

  assign sda_io      = sda_low_q ? 1'b0 : 1'bz;
  assign start_o     = start_q;
  assign ack_error_o = ack_err_q;
  assign cfg_o       = cfg_q;
  assign cfg_vld_o   = vld_q;

  assign scl_s     = scl_sync_q[1];
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  assign plen = 7'd8
              + (ctrl_q[CTRL_FREQ] ? 7'd64 : 7'd0)
              + (ctrl_q[CTRL_DUTY] ? 7'd16 : 7'd0);

  // Bring the bus into the clk domain, idle-high after reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_io};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  // Bus conditions first, then per-state bit handling
  always_comb begin
    state_d   = state;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ctrl_d    = ctrl_q;
    freq_d    = freq_q;
    duty_d    = duty_q;
    pend_d    = pend_q;
    sda_low_d = sda_low_q;
    start_d   = start_q;
    ack_err_d = ack_err_q;
    cfg_d     = cfg_q;
    vld_d     = 1'b0;
    if (stop_det) begin
      if (pend_q) begin
        cfg_d.en   = ctrl_q[CTRL_EN];
        cfg_d.wave = ctrl_q[CTRL_WAVE +: 2];
        if (ctrl_q[CTRL_FREQ]) cfg_d.freq = freq_q[63:32];
        if (ctrl_q[CTRL_DUTY]) cfg_d.duty = duty_q;
        vld_d = 1'b1;
      end
      state_d   = IDLE;
      start_d   = 1'b0;
      sda_low_d = 1'b0;
      pend_d    = 1'b0;
    end else if (start_det) begin
      state_d   = ADDR;
      start_d   = 1'b1;
      ack_err_d = 1'b0;
      cnt_d     = '0;
      pend_d    = 1'b0;
      sda_low_d = 1'b0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise && cnt_q < 7'd8) begin
            addr_d = {addr_q[6:0], sda_s};
            cnt_d  = cnt_q + 7'd1;
          end else if (scl_fall && cnt_q == 7'd8) begin
            if (addr_q == {SLAVE_ADDR, 1'b0}) begin
              state_d   = ADDR_ACK;
              sda_low_d = 1'b1;
            end else begin
              state_d   = IDLE;
              ack_err_d = 1'b1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_d   = DATA;
            sda_low_d = 1'b0;
            cnt_d     = '0;
          end
        end
        DATA: begin
          if (scl_rise && (cnt_q < 7'd8 || cnt_q < plen)) begin
            cnt_d = cnt_q + 7'd1;
            if (cnt_q < 7'd8)
              ctrl_d = {ctrl_q[6:0], sda_s};
            else if (ctrl_q[CTRL_FREQ] && cnt_q < 7'd72)
              freq_d = {freq_q[62:0], sda_s};
            else
              duty_d = {duty_q[14:0], sda_s};
          end else if (scl_fall && cnt_q >= 7'd8 && cnt_q == plen) begin
            state_d   = DATA_ACK;
            sda_low_d = 1'b1;
          end
        end
        DATA_ACK: begin
          if (scl_fall) begin
            state_d   = IDLE;
            sda_low_d = 1'b0;
            pend_d    = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol and shadow state
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      ctrl_q    <= '0;
      freq_q    <= '0;
      duty_q    <= '0;
      pend_q    <= 1'b0;
      sda_low_q <= 1'b0;
      start_q   <= 1'b0;
      ack_err_q <= 1'b0;
      cfg_q     <= '{en: 1'b0, wave: 2'd0, freq: 32'd0, duty: DUTY_RST};
      vld_q     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      ctrl_q    <= ctrl_d;
      freq_q    <= freq_d;
      duty_q    <= duty_d;
      pend_q    <= pend_d;
      sda_low_q <= sda_low_d;
      start_q   <= start_d;
      ack_err_q <= ack_err_d;
      cfg_q     <= cfg_d;
      vld_q     <= vld_d;
    end
  end

endmodule

// File: rtl/i2c_nco_top.sv
// I2C-programmed phase-accumulator NCO (saw/square/triangle/sine).
// Define SINE_LUT_EN to build the quarter-wave sine ROM for wave=3.
module i2c_nco_top
  import i2c_nco_top_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int RESOLUTION  = 12,
  parameter int SAMPLE_RATE = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  inout  wire                   sda,
  output logic [RESOLUTION-1:0] nco_output,
  output logic                  start,
  output logic                  ack_error
);

  localparam int DIV = CLK_FREQ / SAMPLE_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [63:0] INC_SCALE =
    ((64'd1 << 48) + 64'(SAMPLE_RATE / 2)) / 64'(SAMPLE_RATE);
  localparam logic [RESOLUTION-1:0] HALF = RESOLUTION'(1 << (RESOLUTION - 1));

  nco_cfg_t cfg;
  logic     cfg_vld;

  logic              en_q;
  logic [1:0]        wave_q;
  logic [DUTY_W-1:0] duty_q;
  logic [31:0]       inc_q, inc_d;
  logic [CW-1:0]     div_q;
  logic              tick, tick_q;
  logic [31:0]       phase_q;
  logic [RESOLUTION-1:0] out_q, wave_d;
  logic [RESOLUTION-1:0] saw, sq, tri_w, sine;
  logic [RESOLUTION:0]   tri_t;

  i2c_slave i2c_slave_inst (
    .clk_i       (clk),
    .rst_i       (rst),
    .scl_i       (scl),
    .sda_io      (sda),
    .start_o     (start),
    .ack_error_o (ack_error),
    .cfg_o       (cfg),
    .cfg_vld_o   (cfg_vld)
  );

  assign inc_d      = 32'(({32'd0, cfg.freq} * INC_SCALE) >> 16);
  assign tick       = (div_q == CW'(DIV - 1));
  assign nco_output = out_q;

  // Latch committed config and its phase increment
  always_ff @(posedge clk) begin
    if (!rst) begin
      en_q   <= 1'b0;
      wave_q <= 2'd0;
      duty_q <= DUTY_RST;
      inc_q  <= '0;
    end else if (cfg_vld) begin
      en_q   <= cfg.en;
      wave_q <= cfg.wave;
      duty_q <= cfg.duty;
      inc_q  <= inc_d;
    end
  end

  // Sample-rate divider and phase accumulator
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= '0;
    end else begin
      div_q  <= tick ? '0 : div_q + CW'(1);
      tick_q <= tick;
      if (!en_q)
        phase_q <= '0;
      else if (tick)
        phase_q <= phase_q + inc_q;
    end
  end

  assign saw   = phase_q[31 -: RESOLUTION];
  assign tri_t = phase_q[31 -: RESOLUTION + 1];
  assign tri_w = tri_t[RESOLUTION] ? ~tri_t[RESOLUTION-1:0]
                                   : tri_t[RESOLUTION-1:0];
  assign sq    = (phase_q[31:16] < duty_q) ? '1 : '0;

`ifdef SINE_LUT_EN
  logic [RESOLUTION-2:0] rom [64];
  logic [5:0]            ridx;
  logic [RESOLUTION-1:0] amp;

  for (genvar g = 0; g < 64; g++) begin : g_rom
    assign rom[g] = (RESOLUTION - 1)'(sine_amp(g, RESOLUTION));
  end

  assign ridx = phase_q[29:24] ^ {6{phase_q[30]}};
  assign amp  = {1'b0, rom[ridx]};
  assign sine = phase_q[31] ? (HALF - RESOLUTION'(1) - amp) : (HALF + amp);
`else
  assign sine = tri_w;
`endif

  // Waveform select
  always_comb begin
    wave_d = saw;
    unique case (wave_q)
      2'd0: wave_d = saw;
      2'd1: wave_d = sq;
      2'd2: wave_d = tri_w;
      2'd3: wave_d = sine;
      default: wave_d = saw;
    endcase
  end

  // Output register, midscale while disabled
  always_ff @(posedge clk) begin
    if (!rst)
      out_q <= HALF;
    else if (!en_q)
      out_q <= HALF;
    else if (tick_q)
      out_q <= wave_d;
  end

endmodule

// File: tb/tb_i2c_nco_top.sv
// Directed bench for i2c_nco_top over a bit-banged I2C bus.
// Sine checks switch on SINE_LUT_EN like the design.
module tb_i2c_nco_top;

  localparam int R = 12;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         scl = 1'b1;
  logic         sda_low = 1'b0;
  wire          sda;
  logic [R-1:0] nco_output;
  logic         start;
  logic         ack_error;

  int tests = 0;
  int fails = 0;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_nco_top #(
    .CLK_FREQ    (100_000_000),
    .RESOLUTION  (R),
    .SAMPLE_RATE (50_000_000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scl        (scl),
    .sda        (sda),
    .nco_output (nco_output),
    .start      (start),
    .ack_error  (ack_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs,
                         input int lo, input int hi);
    tests++;
    assert (obs >= lo && obs <= hi) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic i2c_start();
    sda_low = 1'b0;
    scl = 1'b1;
    #400;
    sda_low = 1'b1;
    #200;
    scl = 1'b0;
    #100;
  endtask

  task automatic bit_tx(input logic b);
    sda_low = ~b;
    #100;
    scl = 1'b1;
    #200;
    scl = 1'b0;
    #100;
  endtask

  task automatic send_bits(input logic [87:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bit_tx(v[i]);
  endtask

  task automatic ack_slot(output logic s, output logic [2:0] st);
    sda_low = 1'b0;
    #100;
    scl = 1'b1;
    #100;
    s  = sda;
    st = dut.i2c_slave_inst.state;
    #100;
    scl = 1'b0;
    #100;
  endtask

  task automatic i2c_stop();
    sda_low = 1'b1;
    #100;
    scl = 1'b1;
    #200;
    sda_low = 1'b0;
    #400;
  endtask

  task automatic xfer(input string tag, input logic [87:0] pl, input int n);
    logic       a;
    logic [2:0] st;
    i2c_start();
    chk({tag, "_start_hi"}, start, 1);
    send_bits(88'hEA, 8);
    ack_slot(a, st);
    chk({tag, "_aack_sda"}, a, 0);
    chk({tag, "_aack_st"}, st, 2);
    send_bits(pl, n);
    ack_slot(a, st);
    chk({tag, "_dack_sda"}, a, 0);
    chk({tag, "_dack_st"}, st, 4);
    chk({tag, "_start_hold"}, start, 1);
    i2c_stop();
    chk({tag, "_start_lo"}, start, 0);
    repeat (20) @(negedge clk);
  endtask

  task automatic wait_drop(output int cyc, output logic hit);
    logic [R-1:0] prev;
    prev = nco_output;
    cyc  = 0;
    hit  = 1'b0;
    while (!hit && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (nco_output < prev) hit = 1'b1;
      prev = nco_output;
    end
  endtask

  task automatic span(input int n, output int mx, output int mn,
                      output int up, output int dn);
    logic [R-1:0] prev;
    prev = nco_output;
    mx = 0;
    mn = 1 << R;
    up = 0;
    dn = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (int'(nco_output) > mx) mx = int'(nco_output);
      if (int'(nco_output) < mn) mn = int'(nco_output);
      if (nco_output > prev) up++;
      if (nco_output < prev) dn++;
      prev = nco_output;
    end
  endtask

  initial begin
    logic       a;
    logic [2:0] st;
    logic       hit;
    int         cyc, mx, mn, up, dn, hi, lo, oth;

    repeat (5) @(negedge clk);
    chk("rst_out", nco_output, 2048);
    chk("rst_start", start, 0);
    chk("rst_ackerr", ack_error, 0);
    chk("rst_sda", sda, 1);
    chk("rst_state", dut.i2c_slave_inst.state, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    i2c_start();
    send_bits(88'hEC, 8);
    ack_slot(a, st);
    chk("nack_sda", a, 1);
    chk("nack_err", ack_error, 1);
    chk("nack_state", st, 0);
    i2c_stop();
    chk("nack_start_lo", start, 0);
    repeat (20) @(negedge clk);
    chk("nack_cfg_out", nco_output, 2048);

    xfer("saw", {8'h11, 64'h0001D4C0_00000000}, 72);
    chk("saw_err_clr", ack_error, 0);
    for (int k = 0; k < 3; k++) begin
      wait_drop(cyc, hit);
      chk($sformatf("saw_drop%0d", k), hit, 1);
    end
    chk_rng("saw_wrap_low", int'(nco_output), 0, 9);
    wait_drop(cyc, hit);
    chk("saw_drop3", hit, 1);
    chk_rng("saw_period", cyc, 830, 836);

    xfer("tri", 88'h05, 8);
    span(2500, mx, mn, up, dn);
    chk_rng("tri_max", mx, 4076, 4095);
    chk_rng("tri_min", mn, 0, 20);
    chk_rng("tri_sym", up - dn, -6, 6);

    xfer("sq", {8'h23, 16'h4000}, 24);
    hi = 0;
    lo = 0;
    oth = 0;
    for (int i = 0; i < 2500; i++) begin
      repeat (2) @(negedge clk);
      if (nco_output == 12'hFFF) hi++;
      else if (nco_output == 12'h000) lo++;
      else oth++;
    end
    chk("sq_levels", oth, 0);
    chk_rng("sq_high", hi, 610, 640);

    i2c_start();
    send_bits(88'hEA, 8);
    ack_slot(a, st);
    send_bits({8'h11, 64'h00000001_40000000} >> 31, 41);
    sda_low = 1'b0;
    #100;
    scl = 1'b1;
    #100;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_sda", sda, 1);
    chk("rstmid_state", dut.i2c_slave_inst.state, 0);
    chk("rstmid_start", start, 0);
    repeat (5) @(negedge clk);
    chk("rstmid_out", nco_output, 2048);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    xfer("dis", {8'h10, 64'h0001D4C0_00000000}, 72);
    oth = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (nco_output != 12'd2048) oth++;
    end
    chk("dis_out_const", oth, 0);
    chk("dis_phase", dut.phase_q, 0);

    xfer("w3", 88'h07, 8);
    span(2500, mx, mn, up, dn);
`ifdef SINE_LUT_EN
    chk("sin_peak", mx, 4095);
    chk("sin_trough", mn, 0);
`else
    chk_rng("w3_max", mx, 4076, 4095);
    chk_rng("w3_min", mn, 0, 20);
`endif
    chk_rng("w3_sym", up - dn, -6, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
